nasti_lite_write_arbiter: RTL

//  Shares one nasti-lite write slave (AW/W/B) between NUM_MASTER nasti-lite write masters,

---
 rtl/nasti_lite_write_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/nasti_lite_write_arbiter.sv
// nasti_lite_write_arbiter: round-robin sharing of one nasti-lite write slave
// between NUM_MASTER write masters. A grant carries one AW and one W beat; the
// granted index is queued in order so B responses return to their issuer.
module nasti_lite_write_arbiter #(
  parameter int NUM_MASTER   = 2,
  parameter int MAX_OUTSTAND = 4,
  parameter int ID_WIDTH     = 1,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTER*ID_WIDTH-1:0]   s_aw_id,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] s_aw_addr,
  input  logic [NUM_MASTER*3-1:0]          s_aw_prot,
  input  logic [NUM_MASTER-1:0]            s_aw_valid,
  output logic [NUM_MASTER-1:0]            s_aw_ready,
  input  logic [NUM_MASTER*DATA_WIDTH-1:0] s_w_data,
  input  logic [NUM_MASTER*DATA_WIDTH/8-1:0] s_w_strb,
  input  logic [NUM_MASTER-1:0]            s_w_valid,
  output logic [NUM_MASTER-1:0]            s_w_ready,
  output logic [NUM_MASTER*ID_WIDTH-1:0]   s_b_id,
  output logic [NUM_MASTER*2-1:0]          s_b_resp,
  output logic [NUM_MASTER-1:0]            s_b_valid,
  input  logic [NUM_MASTER-1:0]            s_b_ready,
  output logic [ID_WIDTH-1:0]              m_aw_id,
  output logic [ADDR_WIDTH-1:0]            m_aw_addr,
  output logic [2:0]                       m_aw_prot,
  output logic                             m_aw_valid,
  input  logic                             m_aw_ready,
  output logic [DATA_WIDTH-1:0]            m_w_data,
  output logic [DATA_WIDTH/8-1:0]          m_w_strb,
  output logic                             m_w_valid,
  input  logic                             m_w_ready,
  input  logic [ID_WIDTH-1:0]              m_b_id,
  input  logic [1:0]                       m_b_resp,
  input  logic                             m_b_valid,
  output logic                             m_b_ready
);

  localparam int GW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
  localparam int PW = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;
  localparam int CW = $clog2(MAX_OUTSTAND) + 1;
  localparam int SW = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "nasti_lite_write_arbiter: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_MASTER < 2) begin : g_bad_masters
    $fatal(1, "nasti_lite_write_arbiter: NUM_MASTER must be >= 2");
  end

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic            r_aw_done;
  logic            r_w_done;
  logic [GW-1:0]   r_fifo [MAX_OUTSTAND];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [ID_WIDTH-1:0]   w_aw_id   [NUM_MASTER];
  logic [ADDR_WIDTH-1:0] w_aw_addr [NUM_MASTER];
  logic [2:0]            w_aw_prot [NUM_MASTER];
  logic [DATA_WIDTH-1:0] w_w_data  [NUM_MASTER];
  logic [SW-1:0]         w_w_strb  [NUM_MASTER];

  logic            w_req_any;
  logic [GW-1:0]   w_pick;
  int unsigned     w_idx;
  logic            w_granted;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_complete;
  logic            w_pop;
  logic            w_nonempty;
  logic [GW-1:0]   w_head;

  for (genvar g = 0; g < NUM_MASTER; g++) begin : g_unpack
    assign w_aw_id[g]   = s_aw_id[g*ID_WIDTH +: ID_WIDTH];
    assign w_aw_addr[g] = s_aw_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_aw_prot[g] = s_aw_prot[g*3 +: 3];
    assign w_w_data[g]  = s_w_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_w_strb[g]  = s_w_strb[g*SW +: SW];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTAND - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: first requesting AW index at or after rr_ptr.
  always_comb begin
    w_req_any = 1'b0;
    w_pick    = '0;
    w_idx     = 0;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      w_idx = 32'(r_rr_ptr) + i;
      if (w_idx >= NUM_MASTER) w_idx = w_idx - NUM_MASTER;
      if (!w_req_any && s_aw_valid[GW'(w_idx)]) begin
        w_req_any = 1'b1;
        w_pick    = GW'(w_idx);
      end
    end
  end

  assign w_granted  = (r_state == ST_GRANT);
  assign m_aw_valid = w_granted & s_aw_valid[r_grant] & ~r_aw_done;
  assign m_w_valid  = w_granted & s_w_valid[r_grant] & ~r_w_done;
  assign w_aw_hs    = m_aw_valid & m_aw_ready;
  assign w_w_hs     = m_w_valid & m_w_ready;
  assign w_complete = w_granted & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  assign m_aw_id    = w_aw_id[r_grant];
  assign m_aw_addr  = w_aw_addr[r_grant];
  assign m_aw_prot  = w_aw_prot[r_grant];
  assign m_w_data   = w_w_data[r_grant];
  assign m_w_strb   = w_w_strb[r_grant];

  assign w_nonempty = (r_count != '0);
  assign w_head     = r_fifo[r_rd_ptr];
  assign m_b_ready  = w_nonempty & s_b_ready[w_head];
  assign w_pop      = m_b_valid & m_b_ready;
  assign s_b_id     = {NUM_MASTER{m_b_id}};
  assign s_b_resp   = {NUM_MASTER{m_b_resp}};

  // Per-master readies and B valid steered to the granted / head master only.
  always_comb begin
    s_aw_ready = '0;
    s_w_ready  = '0;
    s_b_valid  = '0;
    if (w_granted) begin
      s_aw_ready[r_grant] = m_aw_ready & ~r_aw_done;
      s_w_ready[r_grant]  = m_w_ready & ~r_w_done;
    end
    s_b_valid[w_head] = m_b_valid & w_nonempty;
  end

  // Grant FSM: one IDLE arbitration cycle, then hold until both AW and W complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any && (r_count < CW'(MAX_OUTSTAND))) begin
            r_grant <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_complete) begin
            r_rr_ptr  <= (r_grant == GW'(NUM_MASTER - 1)) ? '0 : r_grant + GW'(1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Response-order FIFO storage; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (w_complete) r_fifo[r_wr_ptr] <= r_grant;
  end

  // Response-order FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_complete) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)      r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
